reaction_seq_ctrl: RTL and testbench

REACTION_SEQ_CTRL -- requirements
Module: reaction_seq_ctrl

---
 rtl/reaction_pkg.sv | 51 +++++
 rtl/reaction_seq_ctrl_tick_gen.sv | 33 +++
 rtl/reaction_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_reaction_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared constants and types for the reaction-time trial controller.
//   - LED color codes (bit0 = R, bit1 = G, bit2 = B) and brightness levels
//   - FSM state encoding
//   - LED output bundle and the per-state LED lookup
package reaction_pkg;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    localparam logic FULL = 1'b1;
    localparam logic SEMI = 1'b0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StGo,
        StDone,
        StFoul,
        StTout
    } state_t;

    typedef struct packed {
        logic [2:0] color1;
        logic       bright1;
        logic [2:0] color2;
        logic       bright2;
    } led_t;

    // LED pattern shown in each state; blink_on selects the lit phase in StFoul.
    function automatic led_t led_of(input state_t st, input logic blink_on);
        led_t l;
        l = '{color1: BLACK, bright1: FULL, color2: WHITE, bright2: SEMI};
        unique case (st)
            StIdle: l = '{color1: BLACK, bright1: FULL, color2: WHITE, bright2: SEMI};
            StArm:  l = '{color1: RED,   bright1: SEMI, color2: BLACK, bright2: FULL};
            StGo:   l = '{color1: GREEN, bright1: FULL, color2: GREEN, bright2: FULL};
            StDone: l = '{color1: BLUE,  bright1: FULL, color2: BLUE,  bright2: SEMI};
            StFoul: l = '{color1: blink_on ? RED : BLACK, bright1: FULL,
                          color2: RED, bright2: FULL};
            StTout: l = '{color1: WHITE, bright1: SEMI, color2: WHITE, bright2: SEMI};
            default: l = '{color1: BLACK, bright1: FULL, color2: WHITE, bright2: SEMI};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/reaction_seq_ctrl_tick_gen.sv
// tick_gen: millisecond tick prescaler.
//   clk   in  system clock
//   rstn  in  asynchronous active-low reset
//   clr   in  synchronous clear; restarts the tick period from the next cycle
//   tick  out one-cycle strobe, TICK_DIV clocks after the last clear
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (clr || presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + CW'(1);
        end
    end

    // A clear in the same cycle wins, so no stale tick leaks into a fresh period.
    assign tick = !clr && (presc == LAST);

endmodule

// File: rtl/reaction_seq_ctrl.sv
// reaction_seq_ctrl: reaction-time trial sequencer.
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   start         in   one-cycle pulse, begins a trial (ignored while busy)
//   hit           in   one-cycle debounced button pulse
//   color1/2      out  LED color codes (bit0 R, bit1 G, bit2 B)
//   bright1/2     out  LED brightness (1 full, 0 semi)
//   result_ms     out  last reaction time in ticks, saturating at TIMEOUT_MS
//   result_valid  out  one-cycle pulse when result_ms is written
//   busy          out  high in ARM and GO
// A trial waits MIN_WAIT_MS plus a pseudo-random number of ticks (ARM), then
// counts ticks until hit (GO). Hit during ARM is a foul.
module reaction_seq_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter int unsigned TIMEOUT_MS  = 9999,
    parameter int unsigned BLINK_MS    = 250
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        hit,
    output logic [2:0]  color1,
    output logic        bright1,
    output logic [2:0]  color2,
    output logic        bright2,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        busy
);

    localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_MS);
    localparam logic [15:0] BLINK   = 16'(BLINK_MS);
    localparam logic [15:0] MIN_DLY = 16'(MIN_WAIT_MS);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] cnt;
    logic [15:0] delay;
    logic        blink_on;
    led_t        led_q;

    logic        tick;
    logic        tick_clr;
    logic [15:0] cnt_inc;
    logic [15:0] cnt_now;
    logic [15:0] hit_result;

    // Taps 16,14,13,11; a nonzero seed keeps this maximal-length sequence off zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        tick_clr   = 1'b0;
        if (start && (state inside {StIdle, StDone, StFoul, StTout})) begin
            tick_clr = 1'b1;
        end
        // Restart the prescaler on a foul so the blink phase is aligned to entry.
        if (state == StArm && hit) begin
            tick_clr = 1'b1;
        end
        cnt_inc    = cnt + 16'd1;
        // A hit on a tick cycle is credited with that tick.
        cnt_now    = tick ? cnt_inc : cnt;
        hit_result = (cnt_now >= TIMEOUT) ? TIMEOUT : cnt_now;
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= StIdle;
            cnt          <= '0;
            delay        <= '0;
            blink_on     <= 1'b1;
            result_ms    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            led_q        <= led_of(StIdle, 1'b1);
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                StIdle, StDone, StFoul, StTout: begin
                    if (start) begin
                        state <= StArm;
                        cnt   <= '0;
                        delay <= MIN_DLY + {5'd0, lfsr[10:0]};
                        busy  <= 1'b1;
                        led_q <= led_of(StArm, 1'b1);
                    end else if (state == StFoul && tick) begin
                        if (cnt_inc >= BLINK) begin
                            cnt      <= '0;
                            blink_on <= ~blink_on;
                            led_q    <= led_of(StFoul, ~blink_on);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                StArm: begin
                    if (hit) begin
                        state    <= StFoul;
                        cnt      <= '0;
                        blink_on <= 1'b1;
                        busy     <= 1'b0;
                        led_q    <= led_of(StFoul, 1'b1);
                    end else if (tick) begin
                        if (cnt_inc >= delay) begin
                            state <= StGo;
                            cnt   <= '0;
                            led_q <= led_of(StGo, 1'b1);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                StGo: begin
                    if (hit) begin
                        state        <= StDone;
                        result_ms    <= 14'(hit_result);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        led_q        <= led_of(StDone, 1'b1);
                    end else if (tick) begin
                        if (cnt_inc >= TIMEOUT) begin
                            state        <= StTout;
                            result_ms    <= 14'(TIMEOUT);
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            led_q        <= led_of(StTout, 1'b1);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    led_q <= led_of(StIdle, 1'b1);
                end
            endcase
        end
    end

    assign color1  = led_q.color1;
    assign bright1 = led_q.bright1;
    assign color2  = led_q.color2;
    assign bright2 = led_q.bright2;

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// Testbench for reaction_seq_ctrl. Timing parameters are scaled down so every
// trial fits comfortably in a short run; expected results go through a queue
// and are popped whenever the DUT pulses result_valid.
module tb_reaction_seq_ctrl;

    localparam int TICK    = 4;
    localparam int MINW    = 20;
    localparam int TIMEOUT = 200;
    localparam int BLINK   = 5;

    // {color1, bright1, color2, bright2}
    localparam logic [7:0] LED_IDLE = 8'b000_1_111_0;
    localparam logic [7:0] LED_ARM  = 8'b001_0_000_1;
    localparam logic [7:0] LED_GO   = 8'b010_1_010_1;
    localparam logic [7:0] LED_DONE = 8'b100_1_100_0;
    localparam logic [7:0] LED_TOUT = 8'b111_0_111_0;
    localparam logic [7:0] LED_FOUL = 8'b001_1_001_1;
    localparam logic [7:0] LED_FOFF = 8'b000_1_001_1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic [2:0]  color1, color2;
    logic        bright1, bright2;
    logic [13:0] result_ms;
    logic        result_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    int          cyc = 0;
    int unsigned exp_q[$];
    logic [15:0] m_lfsr;
    int          go_at, arm_at, t0;

    reaction_seq_ctrl #(
        .TICK_DIV    (TICK),
        .MIN_WAIT_MS (MINW),
        .TIMEOUT_MS  (TIMEOUT),
        .BLINK_MS    (BLINK)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .hit          (hit),
        .color1       (color1),
        .bright1      (bright1),
        .color2       (color2),
        .bright2      (bright2),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: feedback is the parity of the tapped bits 15,13,12,10.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] leds();
        return {color1, bright1, color2, bright2};
    endfunction

    always @(negedge clk) begin
        if (rstn === 1'b1 && result_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) check_eq("spurious_valid", 32'(result_valid), 32'd0);
            else                   check_eq("result_ms", 32'(result_ms), exp_q.pop_front());
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_leds(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_eq(tag, 32'(leds()), 32'(exp));
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Start a trial; the delay uses the LFSR value present in the start cycle.
    task automatic do_start(output int go_cyc, output int arm_cyc);
        int dly;
        dly     = MINW + int'(m_lfsr[10:0]);
        arm_cyc = cyc + 1;
        go_cyc  = arm_cyc + dly * TICK;
        pulse_start();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #20;
        check_eq("rst_leds", 32'(leds()), 32'(LED_IDLE));
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_result", 32'(result_ms), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        goto(cyc + 3);

        // Trial A: normal hit, with start pulses in ARM and GO that must be ignored.
        do_start(go_at, arm_at);
        sample_leds("arm_leds", LED_ARM);
        check_eq("arm_busy", 32'(busy), 32'd1);
        goto(arm_at + 5);
        pulse_start();
        goto(go_at - 1);
        sample_leds("a_pre_go", LED_ARM);
        goto(go_at);
        sample_leds("a_go", LED_GO);
        check_eq("go_busy", 32'(busy), 32'd1);
        goto(go_at + 50);
        pulse_start();
        sample_leds("a_go_after_start", LED_GO);
        goto(go_at + 37 * TICK + 1);
        exp_q.push_back(37);
        pulse_hit();
        sample_leds("a_done", LED_DONE);
        check_eq("done_busy", 32'(busy), 32'd0);
        goto(cyc + 10);
        pulse_hit();
        sample_leds("done_hit_ignored", LED_DONE);
        check_eq("done_result_hold", 32'(result_ms), 32'd37);

        // Trial B: hit during ARM is a foul; color1 blinks every BLINK ticks.
        do_start(go_at, arm_at);
        goto(arm_at + 30);
        pulse_hit();
        t0 = cyc;
        sample_leds("foul_entry", LED_FOUL);
        check_eq("foul_busy", 32'(busy), 32'd0);
        goto(t0 + BLINK * TICK - 1);
        sample_leds("foul_pre_toggle", LED_FOUL);
        goto(t0 + BLINK * TICK);
        sample_leds("foul_off", LED_FOFF);
        goto(t0 + 2 * BLINK * TICK - 1);
        sample_leds("foul_off_end", LED_FOFF);
        goto(t0 + 2 * BLINK * TICK);
        sample_leds("foul_on_again", LED_FOUL);
        check_eq("foul_result_hold", 32'(result_ms), 32'd37);

        // Trial C: hit on the same cycle as the timeout tick takes DONE at TIMEOUT.
        do_start(go_at, arm_at);
        goto(go_at);
        sample_leds("c_go", LED_GO);
        goto(go_at + TIMEOUT * TICK - 1);
        exp_q.push_back(TIMEOUT);
        pulse_hit();
        sample_leds("c_done", LED_DONE);

        // Trial D: no hit runs to timeout.
        do_start(go_at, arm_at);
        sample_leds("d_arm", LED_ARM);
        check_eq("rearm_result_hold", 32'(result_ms), 32'(TIMEOUT));
        goto(go_at);
        sample_leds("d_go", LED_GO);
        exp_q.push_back(TIMEOUT);
        goto(go_at + TIMEOUT * TICK - 1);
        sample_leds("d_pre_tout", LED_GO);
        goto(go_at + TIMEOUT * TICK);
        sample_leds("d_tout", LED_TOUT);
        check_eq("tout_busy", 32'(busy), 32'd0);

        // Trial E: reset during GO aborts immediately, with no result.
        do_start(go_at, arm_at);
        goto(go_at);
        sample_leds("e_go", LED_GO);
        goto(go_at + 20);
        rstn = 1'b0;
        #2;
        check_eq("midrst_leds", 32'(leds()), 32'(LED_IDLE));
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(result_valid), 32'd0);
        check_eq("midrst_result", 32'(result_ms), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        goto(cyc + 5);
        sample_leds("post_rst_idle", LED_IDLE);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        check_eq("valid_pulses", 32'(n_valid), 32'd3);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
